// File: rtl/eprisc_bus_pkg.sv
// Shared types and constants for the EPRISC two-master bus arbiter.
// Optional feature macro used by the arbiter: EPRISC_ARB_LOCK_EN.
package eprisc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned WAIT_CNT_W = 2;
    localparam int unsigned NUM_REQ    = 2;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    // Out-of-range latencies are pulled back into the supported window.
    function automatic int unsigned clamp_rd_lat(input int unsigned lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/eprisc_rr_pick.sv
// Combinational two-way round-robin picker with an optional lock override.
module eprisc_rr_pick
    import eprisc_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    input  logic               lock_hold,
    input  logic               lock_idx,
    output logic               pick_valid_c,
    output logic               pick_idx_c
);

    // Lock wins only while the locked master keeps requesting.
    always_comb begin
        pick_valid_c = |req;
        pick_idx_c   = REQ_CORE;
        if (lock_hold && req[lock_idx]) begin
            pick_idx_c = lock_idx;
        end else if (req == 2'b11) begin
            pick_idx_c = ~last;
        end else if (req[REQ_DMA]) begin
            pick_idx_c = REQ_DMA;
        end
    end

endmodule

// File: rtl/eprisc_bus_arbiter.sv
// Two-master bus arbiter: IDLE -> ISSUE -> (WAIT) -> ACK with round-robin grants.
// Define EPRISC_ARB_LOCK_EN to let a granted master hold the bus via iLock.
module eprisc_bus_arbiter
    import eprisc_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
)(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReq0,
    input  logic              iReq1,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iWData0,
    input  logic [DATA_W-1:0] iWData1,
    input  logic              iWrite0,
    input  logic              iWrite1,
    input  logic              iLock0,
    input  logic              iLock1,
    output logic              oGnt0,
    output logic              oGnt1,
    output logic              oAck0,
    output logic              oAck1,
    output logic [DATA_W-1:0] oRData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic              oMemWrite,
    output logic              oMemEnable,
    input  logic [DATA_W-1:0] iMemRData
);

    localparam int unsigned RD_LAT_EFF = clamp_rd_lat(RD_LAT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        WAIT_CNT_W'((RD_LAT_EFF > 1) ? RD_LAT_EFF - 2 : 0);
    localparam logic READ_NO_WAIT = (RD_LAT_EFF == 1);

    arb_state_t            state, state_d;
    logic                  owner, owner_d;
    logic                  is_write, is_write_d;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic                  last, last_d;
    logic                  gnt0_d, gnt1_d, ack0_d, ack1_d;
    logic                  mem_en_d, mem_wr_d;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_d, rdata_d;

    logic                  lock_hold;
    logic                  pick_valid, pick_idx;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_write;

`ifdef EPRISC_ARB_LOCK_EN
    assign lock_hold = (state == ST_ACK) && ((owner == REQ_DMA) ? iLock1 : iLock0);
`else
    logic unused_lock;
    assign lock_hold   = 1'b0;
    assign unused_lock = iLock0 ^ iLock1;
`endif

    eprisc_rr_pick u_pick (
        .req          ({iReq1, iReq0}),
        .last         (last),
        .lock_hold    (lock_hold),
        .lock_idx     (owner),
        .pick_valid_c (pick_valid),
        .pick_idx_c   (pick_idx)
    );

    assign sel_addr  = (pick_idx == REQ_DMA) ? iAddr1  : iAddr0;
    assign sel_wdata = (pick_idx == REQ_DMA) ? iWData1 : iWData0;
    assign sel_write = (pick_idx == REQ_DMA) ? iWrite1 : iWrite0;

    // Next-state and next-output decode; strobes default low every cycle.
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        is_write_d  = is_write;
        wait_cnt_d  = wait_cnt;
        last_d      = last;
        gnt0_d      = oGnt0;
        gnt1_d      = oGnt1;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = oMemAddr;
        mem_wdata_d = oMemWData;
        rdata_d     = oRData;

        case (state)
            ST_IDLE, ST_ACK: begin
                if (pick_valid) begin
                    state_d     = ST_ISSUE;
                    owner_d     = pick_idx;
                    last_d      = pick_idx;
                    gnt0_d      = (pick_idx == REQ_CORE);
                    gnt1_d      = (pick_idx == REQ_DMA);
                    mem_en_d    = 1'b1;
                    mem_wr_d    = sel_write;
                    is_write_d  = sel_write;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                end else begin
                    state_d = ST_IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (is_write || READ_NO_WAIT) begin
                    state_d = ST_ACK;
                    ack0_d  = (owner == REQ_CORE);
                    ack1_d  = (owner == REQ_DMA);
                    if (!is_write) rdata_d = iMemRData;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = ST_ACK;
                    ack0_d  = (owner == REQ_CORE);
                    ack1_d  = (owner == REQ_DMA);
                    rdata_d = iMemRData;
                end else begin
                    wait_cnt_d = wait_cnt - WAIT_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    // Reset drops any in-flight transaction; pointer favours requester 0 next.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= ST_IDLE;
            owner      <= REQ_CORE;
            is_write   <= 1'b0;
            wait_cnt   <= '0;
            last       <= REQ_DMA;
            oGnt0      <= 1'b0;
            oGnt1      <= 1'b0;
            oAck0      <= 1'b0;
            oAck1      <= 1'b0;
            oMemEnable <= 1'b0;
            oMemWrite  <= 1'b0;
            oMemAddr   <= '0;
            oMemWData  <= '0;
            oRData     <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            is_write   <= is_write_d;
            wait_cnt   <= wait_cnt_d;
            last       <= last_d;
            oGnt0      <= gnt0_d;
            oGnt1      <= gnt1_d;
            oAck0      <= ack0_d;
            oAck1      <= ack1_d;
            oMemEnable <= mem_en_d;
            oMemWrite  <= mem_wr_d;
            oMemAddr   <= mem_addr_d;
            oMemWData  <= mem_wdata_d;
            oRData     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Directed self-checking bench for eprisc_bus_arbiter with RD_LAT=2 and a small RAM model.
module tb_eprisc_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, write0, write1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, ack0, ack1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_write, mem_enable;
    logic [DATA_W-1:0] ram [0:4095];
    logic [5:0]        ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {gnt0, gnt1, ack0, ack1, mem_enable, mem_write};

    always #5 clk = ~clk;

    eprisc_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .iClk(clk), .iRst(rst),
        .iReq0(req0), .iReq1(req1),
        .iAddr0(addr0), .iAddr1(addr1),
        .iWData0(wdata0), .iWData1(wdata1),
        .iWrite0(write0), .iWrite1(write1),
        .iLock0(lock0), .iLock1(lock1),
        .oGnt0(gnt0), .oGnt1(gnt1),
        .oAck0(ack0), .oAck1(ack1),
        .oRData(rdata),
        .oMemAddr(mem_addr), .oMemWData(mem_wdata),
        .oMemWrite(mem_write), .oMemEnable(mem_enable),
        .iMemRData(mem_rdata)
    );

    // RAM with one registered read stage: data valid one cycle after the issue cycle.
    always @(posedge clk) begin
        if (mem_enable && mem_write) ram[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[11:0]];
    end

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (ctl !== 6'b0) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b0);
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== '0) begin
            errors++; $display("FAIL reset_bus: got addr %h wdata %h rdata %h expected all 0",
                               mem_addr, mem_wdata, rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b0) begin
            errors++; $display("FAIL reset_idle: got %b expected %b", ctl, 6'b0);
        end
    endtask

    task automatic test_single_write();
        req0 = 1'b1; addr0 = 32'h100; wdata0 = 32'hDEADBEEF; write0 = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b100011) begin
            errors++; $display("FAIL wr_issue_ctl: got %b expected %b", ctl, 6'b100011);
        end
        checks++;
        if ({mem_addr, mem_wdata} !== {32'h100, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_issue_bus: got %h/%h expected 00000100/deadbeef",
                               mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (ctl !== 6'b101000) begin
            errors++; $display("FAIL wr_ack: got %b expected %b", ctl, 6'b101000);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ram[12'h100] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_ram: got %h expected deadbeef", ram[12'h100]);
        end
        checks++;
        if (ctl !== 6'b0) begin
            errors++; $display("FAIL wr_idle: got %b expected %b", ctl, 6'b0);
        end
    endtask

    task automatic test_read_latency();
        req1 = 1'b1; addr1 = 32'h003; write1 = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b010010 || mem_addr !== 32'h003) begin
            errors++; $display("FAIL rd_issue: got %b addr %h expected %b addr 00000003",
                               ctl, mem_addr, 6'b010010);
        end
        @(negedge clk);
        checks++;
        if (ctl !== 6'b010000) begin
            errors++; $display("FAIL rd_wait: got %b expected %b", ctl, 6'b010000);
        end
        @(negedge clk);
        checks++;
        if (ctl !== 6'b010100) begin
            errors++; $display("FAIL rd_ack: got %b expected %b", ctl, 6'b010100);
        end
        checks++;
        if (rdata !== 32'h800FFFFF) begin
            errors++; $display("FAIL rd_data: got %h expected 800fffff", rdata);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b0 || rdata !== 32'h800FFFFF) begin
            errors++; $display("FAIL rd_hold: got %b rdata %h expected %b rdata 800fffff",
                               ctl, rdata, 6'b0);
        end
    endtask

    task automatic test_drop_before_ack();
        req1 = 1'b1; addr1 = 32'h010; wdata1 = 32'h12345678; write1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b010011) begin
            errors++; $display("FAIL drop_issue: got %b expected %b", ctl, 6'b010011);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b010100) begin
            errors++; $display("FAIL drop_ack: got %b expected %b", ctl, 6'b010100);
        end
        @(negedge clk);
        checks++;
        if (ram[12'h010] !== 32'h12345678 || ctl !== 6'b0) begin
            errors++; $display("FAIL drop_done: got ram %h ctl %b expected 12345678 ctl %b",
                               ram[12'h010], ctl, 6'b0);
        end
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; addr0 = 32'h003; write0 = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b100010) begin
            errors++; $display("FAIL mid_issue: got %b expected %b", ctl, 6'b100010);
        end
        @(negedge clk);
        checks++;
        if (ctl !== 6'b100000) begin
            errors++; $display("FAIL mid_wait: got %b expected %b", ctl, 6'b100000);
        end
        rst = 1'b1; idle_inputs();
        #1;
        checks++;
        if (ctl !== 6'b0) begin
            errors++; $display("FAIL mid_rst_ctl: got %b expected %b", ctl, 6'b0);
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== '0) begin
            errors++; $display("FAIL mid_rst_bus: got addr %h wdata %h rdata %h expected all 0",
                               mem_addr, mem_wdata, rdata);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 6'b0) begin
                errors++; $display("FAIL mid_no_ack[%0d]: got %b expected %b", k, ctl, 6'b0);
            end
        end
        req0 = 1'b1; addr0 = 32'h030; write0 = 1'b1; wdata0 = 32'h0000_0030;
        req1 = 1'b1; addr1 = 32'h031; write1 = 1'b1; wdata1 = 32'h0000_0031;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b100011) begin
            errors++; $display("FAIL mid_tie_after_rst: got %b expected %b", ctl, 6'b100011);
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_tie_and_lock();
        logic [4:0] seq;
        logic [5:0] exp;
        logic       own, issue;
        int         g;
`ifdef EPRISC_ARB_LOCK_EN
        seq = 5'b01000;
`else
        seq = 5'b01010;
`endif
        do_reset();
        req0 = 1'b1; addr0 = 32'h020; wdata0 = 32'h0000_00A0; write0 = 1'b1; lock0 = 1'b1;
        req1 = 1'b1; addr1 = 32'h021; wdata1 = 32'h0000_00B1; write1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            g     = (k - 1) / 2;
            issue = (k % 2) == 1;
            own   = seq[g];
            exp   = {!own, own, !issue && !own, !issue && own, issue, issue};
            checks++;
            if (ctl !== exp) begin
                errors++; $display("FAIL tie_ctl[c%0d]: got %b expected %b", k, ctl, exp);
            end
            if (issue) begin
                checks++;
                if (mem_addr !== (own ? 32'h021 : 32'h020)) begin
                    errors++; $display("FAIL tie_addr[c%0d]: got %h expected %h", k, mem_addr,
                                       own ? 32'h021 : 32'h020);
                end
            end
            if (k == 5) lock0 = 1'b0;
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b0) begin
            errors++; $display("FAIL tie_idle: got %b expected %b", ctl, 6'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        ram[3] = 32'h800FFFFF;
        test_reset();
        test_single_write();
        test_read_latency();
        test_drop_before_ack();
        test_reset_mid_read();
        test_tie_and_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
